// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx
//   Memory-mapped UART transmitter on the yarvi data write bus. Stores to
//   BASE push a byte into a small FIFO. The transmit state machine sends
//   each byte as an 8N1 frame on txd, LSB first. Loads from BASE+1 return
//   the status word:
//     {23'b0, count (zero-extended into [8:3]), overflow, idle, full}
//   Loads from any other address return 0.
//
//   Optional feature: define YARVI_UART_TX_PARITY_EN to insert an even-parity
//   bit between the data bits and the stop bit, which gives 8E1 frames.
//
// Parameters
//   BASE      : word address of the TX data register (status is at BASE+1)
//   DIVISOR   : clock cycles per bit, 2..65535
//   FIFO_LOG2 : FIFO depth is 2**FIFO_LOG2
//
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous, active-high
//   address     : word address from the core
//   writedata   : store data; only [7:0] is used
//   writeenable : one-cycle store strobe
//   readenable  : one-cycle load strobe
//   readdata    : registered load data, valid the cycle after readenable
//   txd         : serial line, idles high
//   busy        : FIFO non-empty or a frame is in flight
//
// Bus handshake: there is no stall. A store or load is taken in the cycle its
// strobe is high. A store to a full FIFO is dropped and sets sticky overflow.
module yarvi_uart_tx #(
    parameter logic [29:0] BASE      = 30'h3FFF_FF00,
    parameter int          DIVISOR   = 434,
    parameter int          FIFO_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] address,
    input  logic [31:0] writedata,
    input  logic        writeenable,
    input  logic        readenable,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        busy
);

    localparam logic [29:0]          STATUS_ADDR = BASE + 30'd1;
    localparam logic [15:0]          BAUD_RELOAD = 16'(DIVISOR - 1);
    localparam logic [FIFO_LOG2:0]   DEPTH       = (FIFO_LOG2+1)'(1 << FIFO_LOG2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [15:0]            baud;
    logic [2:0]             bitidx;
    logic [7:0]             shreg;
`ifdef YARVI_UART_TX_PARITY_EN
    logic                   par;
`endif

    logic [7:0]             mem [2**FIFO_LOG2];
    logic [FIFO_LOG2-1:0]   wr_ptr;
    logic [FIFO_LOG2-1:0]   rd_ptr;
    logic [FIFO_LOG2:0]     count;
    logic                   overflow;

    logic                   empty;
    logic                   full;
    logic                   idle;
    logic                   do_write;
    logic                   push;
    logic                   drop;
    logic                   pop;
    logic                   status_rd;
    logic [7:0]             head;
    logic [31:0]            status_word;
    logic                   unused_bits;

    assign unused_bits = &{1'b0, writedata[31:8]};

    assign empty     = (count == '0);
    assign full      = (count == DEPTH);
    assign idle      = (state == S_IDLE);
    assign busy      = !idle || !empty;
    assign do_write  = writeenable && (address == BASE);
    // A full FIFO rejects the store even if a pop frees a slot this cycle.
    assign push      = do_write && !full;
    assign drop      = do_write && full;
    assign status_rd = readenable && (address == STATUS_ADDR);
    assign head      = mem[rd_ptr];

    // A byte leaves the FIFO from IDLE, or on the last stop-bit cycle so the
    // next start bit follows the stop bit with no idle gap.
    assign pop = !empty && ((state == S_IDLE) ||
                            (state == S_STOP && baud == 16'd0));

    assign status_word = {23'd0, 6'(count), overflow, idle, full};

    // FIFO storage has no reset; only the pointers and count matter.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a status read keeps overflow set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            readdata <= 32'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (status_rd) begin
                overflow <= 1'b0;
            end
            if (readenable) begin
                readdata <= status_rd ? status_word : 32'd0;
            end
        end
    end

    // Transmit FSM. txd is a register, so the async reset drives it high
    // immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            baud   <= 16'd0;
            bitidx <= 3'd0;
            shreg  <= 8'd0;
            txd    <= 1'b1;
`ifdef YARVI_UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                end
                S_START: begin
                    if (baud == 16'd0) begin
                        txd    <= shreg[0];
                        shreg  <= shreg >> 1;
                        bitidx <= 3'd0;
                        baud   <= BAUD_RELOAD;
                        state  <= S_DATA;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud == 16'd0) begin
                        baud <= BAUD_RELOAD;
                        if (bitidx == 3'd7) begin
`ifdef YARVI_UART_TX_PARITY_EN
                            txd   <= par;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bitidx <= bitidx + 3'd1;
                            txd    <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`ifdef YARVI_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud == 16'd0) begin
                        txd   <= 1'b1;
                        baud  <= BAUD_RELOAD;
                        state <= S_STOP;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud == 16'd0) begin
                        state <= S_IDLE;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase

            // Loading a new frame overrides the transitions above. This
            // covers both the IDLE start and the gapless STOP-to-START case.
            if (pop) begin
                shreg <= head;
`ifdef YARVI_UART_TX_PARITY_EN
                par   <= ^head;
`endif
                txd   <= 1'b0;
                baud  <= BAUD_RELOAD;
                state <= S_START;
            end
        end
    end

endmodule
